// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced button level into press, release, long-press and
// double-click strobes, and keeps a running press count.
module btn_event_decoder #(
  parameter int unsigned TIMER_BITS  = 24,
  parameter int unsigned LONG_PERIOD = 1000000,
  parameter int unsigned DBL_PERIOD  = 500000,
  parameter int unsigned CW          = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_btn,
  output logic          o_press,
  output logic          o_release,
  output logic          o_long,
  output logic          o_double,
  output logic          o_held,
  output logic [CW-1:0] o_count
);

  // state  | meaning
  // IDLE   | no press in progress, waiting for a first press
  // PRESS1 | first press held, timing toward a long press
  // WAIT2  | first press released short, double-click window open
  // PRESS2 | second press of a double-click held, timing toward a long press
  // LONG   | long press already reported, waiting for release
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [TIMER_BITS-1:0] LONG_LAST = TIMER_BITS'(LONG_PERIOD - 1);
  localparam logic [TIMER_BITS-1:0] DBL_LAST  = TIMER_BITS'(DBL_PERIOD - 1);
  localparam logic [TIMER_BITS-1:0] TIMER_ONE = TIMER_BITS'(1);
  localparam logic [CW-1:0]         COUNT_ONE = CW'(1);

  state_t                state;
  state_t                state_nxt;
  logic [TIMER_BITS-1:0] timer;
  logic [TIMER_BITS-1:0] timer_nxt;
  logic                  long_nxt;
  logic                  double_nxt;
  logic                  r_last;
  logic                  rise;
  logic                  fall;

  assign rise   = i_btn & ~r_last;
  assign fall   = ~i_btn & r_last;
  assign o_held = r_last;

  // Edge history keeps tracking the button through reset so a held button
  // does not look like a fresh press when reset releases.
  always_ff @(posedge i_clk) begin
    r_last <= i_btn;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      timer     <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_double  <= 1'b0;
      o_count   <= '0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      o_press   <= rise;
      o_release <= fall;
      o_long    <= long_nxt;
      o_double  <= double_nxt;
      if (rise) begin
        o_count <= o_count + COUNT_ONE;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (rise) begin
          state_nxt = PRESS1;
        end
      end
      PRESS1: begin
        // A release on the terminal cycle is still a short press.
        if (fall) begin
          state_nxt = WAIT2;
          timer_nxt = '0;
        end else if (timer == LONG_LAST) begin
          state_nxt = LONG;
          timer_nxt = '0;
          long_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      WAIT2: begin
        // A press on the timeout cycle still counts as the second click.
        if (rise) begin
          state_nxt  = PRESS2;
          timer_nxt  = '0;
          double_nxt = 1'b1;
        end else if (timer == DBL_LAST) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      PRESS2: begin
        if (fall) begin
          state_nxt = IDLE;
          timer_nxt = '0;
        end else if (timer == LONG_LAST) begin
          state_nxt = LONG;
          timer_nxt = '0;
          long_nxt  = 1'b1;
        end else begin
          timer_nxt = timer + TIMER_ONE;
        end
      end
      LONG: begin
        timer_nxt = '0;
        if (fall) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed scenarios plus random button traffic, checked every cycle
// against a timestamp-based model of press/release/long/double events.
module tb_btn_event_decoder;

  localparam int LONG_P = 8;
  localparam int DBL_P  = 6;
  localparam int CW     = 3;

  logic          i_clk   = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_btn   = 1'b0;
  logic          o_press;
  logic          o_release;
  logic          o_long;
  logic          o_double;
  logic          o_held;
  logic [CW-1:0] o_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: events derived from press/release timestamps.
  int t         = 0;
  bit m_last    = 1'b0;
  bit have_press = 1'b0;
  bit press_second = 1'b0;
  bit press_long = 1'b0;
  bit armed     = 1'b0;
  int press_t   = 0;
  int release_t = 0;
  bit e_press, e_release, e_long, e_double;
  int e_count   = 0;

  int n_press_seen = 0;
  int n_release_seen = 0;
  int n_long_seen = 0;
  int n_dbl_seen = 0;

  always #5 i_clk = ~i_clk;

  btn_event_decoder #(
    .TIMER_BITS (4),
    .LONG_PERIOD(LONG_P),
    .DBL_PERIOD (DBL_P),
    .CW         (CW)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_btn    (i_btn),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long),
    .o_double (o_double),
    .o_held   (o_held),
    .o_count  (o_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, t);
    end
  endtask

  task automatic model_edge(input bit rst, input bit btn);
    bit rise_m;
    bit fall_m;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_long    = 1'b0;
    e_double  = 1'b0;
    if (rst) begin
      e_count      = 0;
      have_press   = 1'b0;
      armed        = 1'b0;
      press_long   = 1'b0;
      press_second = 1'b0;
    end else begin
      rise_m    = btn && !m_last;
      fall_m    = !btn && m_last;
      e_press   = rise_m;
      e_release = fall_m;
      if (rise_m) begin
        e_count      = (e_count + 1) % (1 << CW);
        press_second = armed && ((t - release_t) <= DBL_P);
        e_double     = press_second;
        armed        = 1'b0;
        have_press   = 1'b1;
        press_t      = t;
        press_long   = 1'b0;
      end else if (fall_m) begin
        armed      = have_press && !press_long && !press_second;
        release_t  = t;
        have_press = 1'b0;
      end else if (btn && have_press && !press_long && ((t - press_t) == LONG_P)) begin
        e_long     = 1'b1;
        press_long = 1'b1;
      end
    end
    m_last = btn;
  endtask

  task automatic step(input bit rst, input bit btn);
    i_reset = rst;
    i_btn   = btn;
    @(posedge i_clk);
    model_edge(rst, btn);
    #1;
    check("press",   32'(o_press),   32'(e_press));
    check("release", 32'(o_release), 32'(e_release));
    check("long",    32'(o_long),    32'(e_long));
    check("double",  32'(o_double),  32'(e_double));
    check("held",    32'(o_held),    32'(m_last));
    check("count",   32'(o_count),   32'(e_count));
    check("long_dbl_excl", 32'(o_long & o_double), 32'd0);
    n_press_seen   += int'(o_press);
    n_release_seen += int'(o_release);
    n_long_seen    += int'(o_long);
    n_dbl_seen     += int'(o_double);
    t++;
  endtask

  task automatic hold(input bit rst, input bit btn, input int n);
    for (int k = 0; k < n; k++) step(rst, btn);
  endtask

  task automatic clear_seen();
    n_press_seen   = 0;
    n_release_seen = 0;
    n_long_seen    = 0;
    n_dbl_seen     = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lvl;
    hold(1, 0, 3);

    // short click
    clear_seen();
    hold(0, 1, 3); hold(0, 0, 10);
    check("short_count", 32'(o_count), 32'd1);
    check("short_long", 32'(n_long_seen), 32'd0);
    check("short_dbl", 32'(n_dbl_seen), 32'd0);

    // long press, then immediate re-press
    clear_seen();
    hold(0, 1, 12); hold(0, 0, 1); hold(0, 1, 2); hold(0, 0, 10);
    check("long_count", 32'(o_count), 32'd3);
    check("long_pulses", 32'(n_long_seen), 32'd1);
    check("long_no_dbl", 32'(n_dbl_seen), 32'd0);

    // double-click, gap 4
    clear_seen();
    hold(0, 1, 2); hold(0, 0, 4); hold(0, 1, 2); hold(0, 0, 10);
    check("dbl_count", 32'(o_count), 32'd5);
    check("dbl_pulses", 32'(n_dbl_seen), 32'd1);

    // gap 7: too slow
    clear_seen();
    hold(0, 1, 2); hold(0, 0, 7); hold(0, 1, 2); hold(0, 0, 10);
    check("slow_count", 32'(o_count), 32'd7);
    check("slow_no_dbl", 32'(n_dbl_seen), 32'd0);

    // gap 6: rise on the timeout cycle
    clear_seen();
    hold(0, 1, 2); hold(0, 0, 6); hold(0, 1, 2); hold(0, 0, 10);
    check("edge_dbl_count", 32'(o_count), 32'd1);
    check("edge_dbl_pulses", 32'(n_dbl_seen), 32'd1);

    // fall on the terminal long cycle stays short
    clear_seen();
    hold(0, 1, 8); hold(0, 0, 10);
    check("hold_edge_count", 32'(o_count), 32'd2);
    check("hold_edge_no_long", 32'(n_long_seen), 32'd0);

    // counter wrap
    hold(1, 0, 2);
    for (int i = 0; i < 9; i++) begin
      hold(0, 1, 2); hold(0, 0, 8);
      check("wrap_count", 32'(o_count), 32'((i + 1) % 8));
    end

    // reset mid-press with button held
    hold(0, 1, 3); hold(1, 1, 2);
    clear_seen();
    hold(0, 1, 12);
    check("rst_no_press", 32'(n_press_seen), 32'd0);
    check("rst_no_long", 32'(n_long_seen), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_held", 32'(o_held), 32'd1);
    hold(0, 0, 3);
    check("rst_release", 32'(n_release_seen), 32'd1);

    // random traffic
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        lvl = 1'($urandom_range(0, 1));
        hold(1, lvl, $urandom_range(1, 3));
      end else begin
        lvl = ~lvl;
        hold(0, lvl, $urandom_range(1, 12));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
